// File: rtl/sonic_vc_pkg.sv
// Shared types for the virtual-channel TX mux: beat record, FSM states and the
// TC stamping helper.
package sonic_vc_pkg;

    localparam int TC_LSB      = 20;
    localparam int TC_W        = 3;
    localparam int BEAT_DATA_W = 64;

    typedef struct packed {
        logic                   sop;
        logic                   eop;
        logic                   err;
        logic [BEAT_DATA_W-1:0] data;
    } beat_t;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } tx_state_e;

    // Overwrites the TC field of header DW0; every other bit passes through.
    function automatic logic [BEAT_DATA_W-1:0] stamp_tc(input logic [BEAT_DATA_W-1:0] d,
                                                        input logic [TC_W-1:0]        tc);
        logic [BEAT_DATA_W-1:0] r;
        r = d;
        r[TC_LSB +: TC_W] = tc;
        return r;
    endfunction

endpackage

// File: rtl/sonic_vc_skid_buf.sv
// Two-entry valid/ready register pipe of beat_t. Outputs come straight from
// flops; the space flag is a flop too, so upstream ready has no path from out_ready.
module sonic_vc_skid_buf
    import sonic_vc_pkg::*;
(
    input  logic  clk_in,
    input  logic  rst,
    input  logic  in_valid,
    input  beat_t in_beat,
    output logic  in_space,
    output logic  out_valid,
    output beat_t out_beat,
    input  logic  out_ready
);

    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       space_q;
    beat_t      head_q;
    beat_t      skid_q;
    logic       push;
    logic       pop;

    assign out_valid = (count_q != 2'd0);
    assign out_beat  = head_q;
    assign in_space  = space_q;
    assign push      = in_valid & space_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_d = count_q;
        case (count_q)
            2'd0: if (push) count_d = 2'd1;
            2'd1: begin
                if (push && !pop)      count_d = 2'd2;
                else if (!push && pop) count_d = 2'd0;
            end
            2'd2: if (pop) count_d = 2'd1;
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
            space_q <= 1'b1;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            count_q <= count_d;
            space_q <= (count_d != 2'd2);
            case (count_q)
                2'd0: if (push) head_q <= in_beat;
                2'd1: begin
                    if (push && pop) head_q <= in_beat;
                    else if (push)   skid_q <= in_beat;
                end
                2'd2: if (pop) head_q <= skid_q;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sonic_vc_tx_mux.sv
// Packet-atomic round-robin merge of NUM_CHAN TLP streams onto tx_st, stamping
// the channel index into the TC field so the RX demux can recover it.
module sonic_vc_tx_mux
    import sonic_vc_pkg::*;
#(
    parameter int NUM_CHAN = 4,
    parameter int DATA_W   = BEAT_DATA_W,
    parameter int STAMP_TC = 1
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic [NUM_CHAN-1:0]      ch_valid,
    input  logic [NUM_CHAN-1:0]      ch_sop,
    input  logic [NUM_CHAN-1:0]      ch_eop,
    input  logic [NUM_CHAN-1:0]      ch_err,
    input  logic [NUM_CHAN*DATA_W-1:0] ch_data,
    output logic [NUM_CHAN-1:0]      ch_ready,
    output logic                     tx_st_valid,
    output logic                     tx_st_sop,
    output logic                     tx_st_eop,
    output logic                     tx_st_err,
    output logic [DATA_W-1:0]        tx_st_data,
    input  logic                     tx_st_ready,
    output logic [31:0]              tx_pkt_cnt,
    output logic                     proto_err
);

    localparam int PTR_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

    tx_state_e            state_q, state_d;
    logic [PTR_W-1:0]     gnt_q, gnt_d;
    logic [PTR_W-1:0]     rr_q, rr_d;
    logic [NUM_CHAN-1:0]  cand;
    logic [NUM_CHAN-1:0]  ready_int;
    logic [PTR_W-1:0]     pick;
    logic                 found;
    logic                 drain_hit;
    logic                 push;
    beat_t                push_beat;
    logic                 space;
    beat_t                out_beat;
    logic [DATA_W-1:0]    sel_data;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_CHAN) s = s - NUM_CHAN;
        return PTR_W'(s);
    endfunction

    // First SOP candidate at or after rr_q, wrapping.
    always_comb begin
        cand  = ch_valid & ch_sop;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_CHAN; k++) begin
            if (!found && cand[wrap_add(rr_q, k)]) begin
                found = 1'b1;
                pick  = wrap_add(rr_q, k);
            end
        end
    end

    assign sel_data = ch_data[int'(gnt_q)*DATA_W +: DATA_W];

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_d      = rr_q;
        ready_int = '0;
        drain_hit = 1'b0;
        push      = 1'b0;
        push_beat = '0;
        case (state_q)
            IDLE: begin
                // Orphan mid-packet beats are swallowed so they cannot wedge a channel.
                ready_int = ch_valid & ~ch_sop;
                drain_hit = |ready_int;
                if (found) begin
                    gnt_d   = pick;
                    rr_d    = wrap_add(pick, 1);
                    state_d = LOCK;
                end
            end
            LOCK: begin
                ready_int[gnt_q] = space;
                push_beat.sop    = ch_sop[gnt_q];
                push_beat.eop    = ch_eop[gnt_q];
                push_beat.err    = ch_err[gnt_q];
                push_beat.data   = sel_data;
                if (STAMP_TC != 0 && ch_sop[gnt_q])
                    push_beat.data = stamp_tc(sel_data, TC_W'(gnt_q));
                if (ch_valid[gnt_q] && space) begin
                    push = 1'b1;
                    if (ch_eop[gnt_q]) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ch_ready = rst ? '0 : ready_int;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            rr_q       <= '0;
            proto_err  <= 1'b0;
            tx_pkt_cnt <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
            proto_err <= proto_err | drain_hit;
            if (tx_st_valid && tx_st_ready && tx_st_eop)
                tx_pkt_cnt <= tx_pkt_cnt + 32'd1;
        end
    end

    sonic_vc_skid_buf u_skid (
        .clk_in    (clk_in),
        .rst       (rst),
        .in_valid  (push),
        .in_beat   (push_beat),
        .in_space  (space),
        .out_valid (tx_st_valid),
        .out_beat  (out_beat),
        .out_ready (tx_st_ready)
    );

    assign tx_st_sop  = out_beat.sop;
    assign tx_st_eop  = out_beat.eop;
    assign tx_st_err  = out_beat.err;
    assign tx_st_data = out_beat.data;

endmodule
